shift_engine: RTL and testbench
===============================

Name: shift_engine

Overview:
Parametrised successor to the single-step shift register: a multi-lane shift engine.
- Accepts a parallel word plus a step count through a valid/ready handshake.
- Autonomously shifts LANES bits per cycle for the requested number of steps, then pulses done.
- Supports logical, rotate and arithmetic modes in either direction, with LANES-wide serial in/out.
- Sits beside SoC peripherals (SPI/UART-style serialisers, bit-field extraction) as the shared shift datapath.

Parameters:
WIDTH, 8, data word width in bits; must be a multiple of LANES.
LANES, 1, bits shifted per step; 1 <= LANES <= WIDTH/2.
CNT_W, $clog2(WIDTH/LANES)+1, step-counter width (derived; do not override).

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  asynchronous active-low reset
start_valid_i  in  1  request to start an operation
start_ready_o  out  1  engine idle and able to accept a request
parallel_i  in  WIDTH  initial word, captured on accept
count_i  in  CNT_W  number of steps, captured on accept
dir_i  in  1  0 = left (toward MSB), 1 = right; captured on accept
mode_i  in  2  00 logical, 01 rotate, 10 arithmetic, 11 reserved (treated as logical); captured on accept
hold_i  in  1  pause shifting while high in SHIFT
serial_i  in  LANES  fill bits for logical mode, sampled every shift step
serial_o  out  LANES  outgoing lanes: data[WIDTH-1 -: LANES] when left, data[LANES-1:0] when right
data_o  out  WIDTH  current register contents
busy_o  out  1  high in SHIFT and DONE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: data_o = 0, FSM = IDLE, start_ready_o = 1, busy_o = 0, done_o = 0, counter = 0, latched dir/mode = 0.
- FSM states: IDLE, SHIFT, DONE. start_ready_o = (state == IDLE). The handshake is a plain AND; there is no combinational path from start_valid_i to start_ready_o.
- Accept (IDLE, start_valid_i = 1) at edge k:
  - data <= parallel_i.
  - cnt <= min(count_i, WIDTH/LANES).
  - dir and mode are latched.
  - Next state is SHIFT if the clamped count is nonzero, otherwise DONE.
- SHIFT, hold_i = 0: one step per edge, then cnt decrements. When cnt == 1 before the step, next state is DONE.
- SHIFT, hold_i = 1: data and cnt are frozen; serial_i is ignored.
- Latency: N steps occur at edges k+1 .. k+N (with no hold). done_o is high in the cycle following edge k+N. start_ready_o returns at edge k+N+1. The minimum back-to-back interval is N+2 cycles.
- DONE: done_o = 1 for exactly one cycle, then IDLE. data_o holds its final value until the next accept.
- Step rules, left: data <= {data[WIDTH-LANES-1:0], fill}.
  - logical: fill = serial_i.
  - rotate: fill = data[WIDTH-1 -: LANES].
  - arithmetic: fill = 0.
- Step rules, right: data <= {fill, data[WIDTH-1:LANES]}.
  - logical: fill = serial_i.
  - rotate: fill = data[LANES-1:0].
  - arithmetic: fill = LANES copies of data[WIDTH-1].
- serial_o is combinational from data and the latched dir. In IDLE it uses dir_i.
- Boundaries:
  - count_i = 0 produces a done pulse with data = parallel_i and no shift.
  - count_i > WIDTH/LANES is clamped, so a logical shift fully flushes the word.
  - start_valid_i in SHIFT or DONE is ignored (not accepted).
  - Reset asserted mid-operation returns every output to its reset value immediately, with no done pulse.

Optional Feature:
Macro SHIFT_ENGINE_ABORT_EN.
- Defined: adds input abort_i (1 bit).
  - In SHIFT or DONE, abort_i = 1 forces IDLE at the next edge, data frozen, no done_o.
  - An abort in the same cycle as DONE suppresses that done pulse.
  - abort_i in IDLE has no effect.
  - abort_i takes priority over hold_i.
- Undefined: the port is absent; an operation always runs to completion.

Test Plan:
- WIDTH=8, LANES=1, logical left, parallel 0x01, count 3, serial_i=0 -> data_o 0x02, 0x04, 0x08 on edges k+1..k+3; done_o high the following cycle only; start_ready_o returns at k+4.
- Rotate left 0x81, count 1 -> 0x03. Rotate right 0x81, count 1 -> 0xC0. Arithmetic right 0x80, count 3 -> 0xF0. Logical right 0x80, count 3 -> 0x10.
- LANES=2, logical left, 0xA5, count 2, serial_i=2'b11 -> serial_o 2'b10 then 2'b10; data 0x97 then 0x5F; done after step 2.
- count 0 with parallel 0x3C -> no shift, done_o the cycle after accept, data_o 0x3C. count 15 (clamped to 8), logical left, serial_i=0 -> 0x00 after 8 steps.
- hold_i high 2 cycles during a count-3 shift -> done delayed by exactly 2 cycles, final value unchanged. start_valid_i held high throughout -> a second accept occurs only in IDLE.
- rst_ni low during step 2 of 4 -> data_o 0, start_ready_o 1, no done_o. With SHIFT_ENGINE_ABORT_EN: abort_i at step 2 -> IDLE, data frozen at the step-2 value, no done_o.

Source files
------------

// File: rtl/shift_engine.sv
// Multi-lane shift engine: valid/ready accept, LANES bits per step, done pulse.
// Optional macro SHIFT_ENGINE_ABORT_EN adds abort_i to cancel a running operation.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int CNT_W = $clog2(WIDTH/LANES)+1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [WIDTH-1:0] parallel_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             hold_i,
  input  logic [LANES-1:0] serial_i,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [LANES-1:0] serial_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH/LANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_nx;
  logic [WIDTH-1:0] data_r, data_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic             dir_r, dir_nx;
  logic [1:0]       mode_r, mode_nx;
  logic             ready_r, busy_r, done_r;
  logic             abort_s;
  logic             dir_eff_s;

`ifdef SHIFT_ENGINE_ABORT_EN
  assign abort_s = abort_i;
`else
  assign abort_s = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic             dr,
    input logic [1:0]       m,
    input logic [LANES-1:0] ser
  );
    logic [LANES-1:0] fill;
    if (!dr) begin
      case (m)
        2'b01:   fill = d[WIDTH-1 -: LANES];
        2'b10:   fill = {LANES{1'b0}};
        default: fill = ser;
      endcase
      return {d[WIDTH-LANES-1:0], fill};
    end else begin
      case (m)
        2'b01:   fill = d[LANES-1:0];
        2'b10:   fill = {LANES{d[WIDTH-1]}};
        default: fill = ser;
      endcase
      return {fill, d[WIDTH-1:LANES]};
    end
  endfunction

  // Next-state and datapath decode
  always_comb begin
    state_nx = state_r;
    data_nx  = data_r;
    cnt_nx   = cnt_r;
    dir_nx   = dir_r;
    mode_nx  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (start_valid_i) begin
          data_nx  = parallel_i;
          cnt_nx   = (count_i > MAX_STEPS) ? MAX_STEPS : count_i;
          dir_nx   = dir_i;
          mode_nx  = mode_i;
          state_nx = (cnt_nx == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort_s) begin
          state_nx = ST_IDLE;
        end else if (hold_i) begin
          state_nx = ST_SHIFT;
        end else begin
          data_nx  = shift_step(data_r, dir_r, mode_r, serial_i);
          cnt_nx   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          state_nx = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      data_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dir_r   <= 1'b0;
      mode_r  <= 2'b00;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      data_r  <= data_nx;
      cnt_r   <= cnt_nx;
      dir_r   <= dir_nx;
      mode_r  <= mode_nx;
      ready_r <= (state_nx == ST_IDLE);
      busy_r  <= (state_nx != ST_IDLE);
      done_r  <= (state_nx == ST_DONE);
    end
  end

  // In IDLE the outgoing lanes follow the requested direction, otherwise the latched one
  assign dir_eff_s     = (state_r == ST_IDLE) ? dir_i : dir_r;
  assign serial_o      = dir_eff_s ? data_r[LANES-1:0] : data_r[WIDTH-1 -: LANES];
  assign data_o        = data_r;
  assign start_ready_o = ready_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r & ~abort_s;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: an 8x1 and an 8x2 instance against an
// arithmetic reference model of the shift rules.
module tb_shift_engine;

  logic       clk, rst_n;
  logic       sv, rdy, dir, hold, ser, ser_o, busy, done, abort;
  logic [7:0] par, data;
  logic [3:0] cnt;
  logic [1:0] mode;

  logic       sv2, rdy2, dir2, hold2, busy2, done2, abort2;
  logic [7:0] par2, data2;
  logic [2:0] cnt2;
  logic [1:0] mode2, ser2, ser_o2;

  int checks = 0;
  int errors = 0;

  shift_engine #(.WIDTH(8), .LANES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(sv), .start_ready_o(rdy),
    .parallel_i(par), .count_i(cnt), .dir_i(dir), .mode_i(mode), .hold_i(hold),
    .serial_i(ser),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort_i(abort),
`endif
    .serial_o(ser_o), .data_o(data), .busy_o(busy), .done_o(done)
  );

  shift_engine #(.WIDTH(8), .LANES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_valid_i(sv2), .start_ready_o(rdy2),
    .parallel_i(par2), .count_i(cnt2), .dir_i(dir2), .mode_i(mode2), .hold_i(hold2),
    .serial_i(ser2),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort_i(abort2),
`endif
    .serial_o(ser_o2), .data_o(data2), .busy_o(busy2), .done_o(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: treat the word as an integer; shift by l and merge the fill value.
  function automatic logic [7:0] ref_step(input logic [7:0] d, input logic dr,
                                          input logic [1:0] m, input int sr, input int l);
    int v, mask, fill, r;
    v = int'(d);
    mask = (1 << l) - 1;
    if (!dr) begin
      if (m == 2'd1) fill = v >> (8 - l);
      else if (m == 2'd2) fill = 0;
      else fill = sr & mask;
      r = (v << l) | fill;
    end else begin
      if (m == 2'd1) fill = v & mask;
      else if (m == 2'd2) fill = d[7] ? mask : 0;
      else fill = sr & mask;
      r = (v >> l) | (fill << (8 - l));
    end
    return 8'(r);
  endfunction

  function automatic logic [1:0] ref_sout(input logic [7:0] d, input logic dr, input int l);
    int v;
    v = int'(d);
    return dr ? 2'(v & ((1 << l) - 1)) : 2'(v >> (8 - l));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; sv = 1'b0; par = 8'h00; cnt = 4'd0; dir = 1'b0; mode = 2'd0;
    hold = 1'b0; ser = 1'b0; abort = 1'b0;
    sv2 = 1'b0; par2 = 8'h00; cnt2 = 3'd0; dir2 = 1'b0; mode2 = 2'd0;
    hold2 = 1'b0; ser2 = 2'd0; abort2 = 1'b0;
    #12;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b done %b want 0 0", busy, done); end
    checks++; if (data2 !== 8'h00 || rdy2 !== 1'b1) begin errors++; $display("FAIL reset_dut2: data %h ready %b want 00 1", data2, rdy2); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: ready %b busy %b want 1 0", rdy, busy); end
  endtask

  // Drives one operation on the 8x1 instance; fixed_ser < 0 means random serial_i.
  task automatic run_op(input logic [7:0] p, input logic [3:0] n, input logic d,
                        input logic [1:0] m, input int hold_at, input int hold_len,
                        input int fixed_ser, output logic [7:0] fin);
    logic [7:0] exp;
    int steps, done_steps, c, s;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL op_ready_before: got %b want 1", rdy); end
    sv = 1'b1; par = p; cnt = n; dir = d; mode = m;
    @(posedge clk); #1;
    sv = 1'b0; par = 8'($urandom); dir = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
    exp = p;
    steps = (n > 4'd8) ? 8 : int'(n);
    checks++; if (data !== p) begin errors++; $display("FAIL op_load: got %h want %h", data, p); end
    checks++; if (busy !== 1'b1 || rdy !== 1'b0) begin errors++; $display("FAIL op_busy: busy %b ready %b want 1 0", busy, rdy); end
    checks++; if (done !== (steps == 0)) begin errors++; $display("FAIL op_done_accept: got %b want %b", done, steps == 0); end
    done_steps = 0; c = 0;
    while (done_steps < steps && c < 64) begin
      hold = (c >= hold_at && c < hold_at + hold_len);
      s = (fixed_ser < 0) ? int'($urandom_range(0, 1)) : fixed_ser;
      ser = 1'(s);
      checks++; if (ser_o !== (d ? exp[0] : exp[7])) begin errors++; $display("FAIL op_serial_o: got %b want %b", ser_o, d ? exp[0] : exp[7]); end
      if (!hold) begin
        exp = ref_step(exp, d, m, s, 1);
        done_steps++;
      end
      @(posedge clk); #1;
      checks++; if (data !== exp) begin errors++; $display("FAIL op_step%0d: got %h want %h", c, data, exp); end
      checks++; if (done !== (done_steps == steps)) begin errors++; $display("FAIL op_done_cycle%0d: got %b want %b", c, done, done_steps == steps); end
      c++;
    end
    hold = 1'b0;
    if (c >= 64) begin errors++; checks++; $display("FAIL op_timeout: %0d of %0d steps", done_steps, steps); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || rdy !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL op_end: done %b ready %b busy %b want 0 1 0", done, rdy, busy); end
    checks++; if (data !== exp) begin errors++; $display("FAIL op_final: got %h want %h", data, exp); end
    fin = exp;
  endtask

  task automatic test_vectors();
    logic [7:0] f;
    run_op(8'h01, 4'd3, 1'b0, 2'd0, 99, 0, 0, f);
    checks++; if (data !== 8'h08) begin errors++; $display("FAIL vec_lsl3: got %h want 08", data); end
    run_op(8'h81, 4'd1, 1'b0, 2'd1, 99, 0, -1, f);
    checks++; if (data !== 8'h03) begin errors++; $display("FAIL vec_rol: got %h want 03", data); end
    run_op(8'h81, 4'd1, 1'b1, 2'd1, 99, 0, -1, f);
    checks++; if (data !== 8'hC0) begin errors++; $display("FAIL vec_ror: got %h want c0", data); end
    run_op(8'h80, 4'd3, 1'b1, 2'd2, 99, 0, -1, f);
    checks++; if (data !== 8'hF0) begin errors++; $display("FAIL vec_asr: got %h want f0", data); end
    run_op(8'h80, 4'd3, 1'b1, 2'd0, 99, 0, 0, f);
    checks++; if (data !== 8'h10) begin errors++; $display("FAIL vec_lsr: got %h want 10", data); end
    run_op(8'h3C, 4'd0, 1'b0, 2'd0, 99, 0, -1, f);
    checks++; if (data !== 8'h3C) begin errors++; $display("FAIL vec_count0: got %h want 3c", data); end
    run_op(8'hA5, 4'd15, 1'b0, 2'd0, 99, 0, 0, f);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL vec_clamp: got %h want 00", data); end
  endtask

  task automatic test_hold();
    logic [7:0] f;
    run_op(8'h01, 4'd3, 1'b0, 2'd0, 1, 2, 0, f);
    checks++; if (data !== 8'h08) begin errors++; $display("FAIL hold_final: got %h want 08", data); end
  endtask

  task automatic test_random();
    logic [7:0] f;
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), -1, f);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    sv = 1'b1; par = 8'h5A; cnt = 4'd2; dir = 1'b0; mode = 2'd1;
    @(posedge clk); #1;
    par = 8'hE7; cnt = 4'd1; dir = 1'b1; mode = 2'd0;
    checks++; if (data !== 8'h5A) begin errors++; $display("FAIL b2b_load: got %h want 5a", data); end
    @(posedge clk); #1;
    checks++; if (data !== 8'hB4) begin errors++; $display("FAIL b2b_step1: got %h want b4", data); end
    @(posedge clk); #1;
    checks++; if (data !== 8'h69 || done !== 1'b1) begin errors++; $display("FAIL b2b_step2: data %h done %b want 69 1", data, done); end
    @(posedge clk); #1;
    checks++; if (data !== 8'h69 || rdy !== 1'b1) begin errors++; $display("FAIL b2b_idle: data %h ready %b want 69 1", data, rdy); end
    @(posedge clk); #1;
    sv = 1'b0;
    checks++; if (data !== 8'hE7 || busy !== 1'b1) begin errors++; $display("FAIL b2b_second: data %h busy %b want e7 1", data, busy); end
    c = 0;
    while (rdy !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_drain: ready %b after %0d cycles", rdy, c); end
  endtask

  task automatic test_reset_mid();
    sv = 1'b1; par = 8'h96; cnt = 4'd4; dir = 1'b0; mode = 2'd0; ser = 1'b0;
    @(posedge clk); #1; sv = 1'b0;
    @(posedge clk); #1;
    checks++; if (data !== 8'h2C) begin errors++; $display("FAIL rmid_step1: got %h want 2c", data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data !== 8'h00 || rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rmid_reset: data %h ready %b busy %b done %b", data, rdy, busy, done); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL rmid_after%0d: done %b ready %b want 0 1", i, done, rdy); end
    end
  endtask

  task automatic test_lanes2();
    logic [7:0] p, exp;
    logic [1:0] m, so;
    logic d;
    int steps, sr, n;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin p = 8'hA5; n = 2; d = 1'b0; m = 2'd0; end
      else begin
        p = 8'($urandom); n = int'($urandom_range(0, 7));
        d = 1'($urandom_range(0, 1)); m = 2'($urandom_range(0, 3));
      end
      sv2 = 1'b1; par2 = p; cnt2 = 3'(n); dir2 = d; mode2 = m;
      @(posedge clk); #1; sv2 = 1'b0; dir2 = ~d;
      exp = p; steps = (n > 4) ? 4 : n;
      checks++; if (done2 !== (steps == 0)) begin errors++; $display("FAIL l2_done_accept: got %b want %b", done2, steps == 0); end
      for (int s = 0; s < steps; s++) begin
        sr = (i == 0) ? 3 : int'($urandom_range(0, 3));
        ser2 = 2'(sr);
        so = ref_sout(exp, d, 2);
        checks++; if (ser_o2 !== so) begin errors++; $display("FAIL l2_serial_o: got %b want %b", ser_o2, so); end
        exp = ref_step(exp, d, m, sr, 2);
        @(posedge clk); #1;
        checks++; if (data2 !== exp) begin errors++; $display("FAIL l2_step: got %h want %h", data2, exp); end
        checks++; if (done2 !== (s == steps - 1)) begin errors++; $display("FAIL l2_done: got %b want %b", done2, s == steps - 1); end
        if (i == 0 && s == 0) begin
          checks++; if (data2 !== 8'h97) begin errors++; $display("FAIL l2_vec1: got %h want 97", data2); end
        end
      end
      @(posedge clk); #1;
      checks++; if (rdy2 !== 1'b1 || done2 !== 1'b0 || data2 !== exp) begin
        errors++; $display("FAIL l2_end: ready %b done %b data %h want 1 0 %h", rdy2, done2, data2, exp); end
      if (i == 0) begin
        checks++; if (data2 !== 8'h5F) begin errors++; $display("FAIL l2_vec2: got %h want 5f", data2); end
      end
    end
  endtask

`ifdef SHIFT_ENGINE_ABORT_EN
  task automatic test_abort();
    sv = 1'b1; par = 8'h96; cnt = 4'd4; dir = 1'b0; mode = 2'd0; ser = 1'b1;
    @(posedge clk); #1; sv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (data !== 8'h5B) begin errors++; $display("FAIL abort_step2: got %h want 5b", data); end
    abort = 1'b1; hold = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; hold = 1'b0;
    checks++; if (data !== 8'h5B || rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: data %h ready %b busy %b done %b", data, rdy, busy, done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || data !== 8'h5B) begin errors++; $display("FAIL abort_nodone: done %b data %h", done, data); end
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_lanes2();
`ifdef SHIFT_ENGINE_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
